apb_timer_ctrl: RTL and testbench
=================================

APB_TIMER_CTRL -- requirements
Module: apb_timer_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data width of the APB bus, registers and counter.
REQ-002 SHALL have parameter PW, default 4, meaning prescaler field width, with PW <= DW-4.
REQ-003 PCLK  in  1  clock; all state updates on the rising edge.
REQ-004 PRESETn  in  1  asynchronous, active-low reset.
REQ-005 PSEL  in  1  APB select.
REQ-006 PENABLE  in  1  APB access phase.
REQ-007 PWRITE  in  1  1 = write, 0 = read.
REQ-008 PADDR  in  2  register index: 0 LOAD, 1 CTRL, 2 STATUS, 3 COUNT.
REQ-009 PWDATA  in  DW  write data.
REQ-010 PRDATA  out  DW  read data.
REQ-011 PREADY  out  1  transfer ready; tied to 1 (zero wait states).
REQ-012 PSLVERR  out  1  transfer error.
REQ-013 irq  out  1  timer interrupt, level.

Function
REQ-014 SHALL commit a write on the PCLK edge where PSEL=1, PENABLE=1 and PWRITE=1.
REQ-015 SHALL drive PRDATA combinationally from the register at PADDR when PSEL=1, PENABLE=1 and PWRITE=0, and drive PRDATA=0 otherwise.
REQ-016 LOAD (RW) SHALL hold the reload value.
REQ-017 CTRL (RW) SHALL provide bit0 EN, bit1 MODE (0 one-shot, 1 periodic), bit2 IE, bits[4+PW-1:4] PRESC; all other bits SHALL read 0.
REQ-018 STATUS bit0 FLAG SHALL be write-1-to-clear, bit1 RUNNING SHALL be read-only, and all other bits SHALL read 0.
REQ-019 COUNT SHALL be read-only and return the current counter value.
REQ-020 PSLVERR SHALL be 1 only in an access phase that writes PADDR=3; that write SHALL change no state.
REQ-021 The FSM SHALL have exactly three states: IDLE, LOAD, RUN; RUNNING SHALL be 1 when state != IDLE.
REQ-022 A CTRL write that takes EN from 0 to 1 SHALL move the FSM from IDLE to LOAD on the commit edge.
REQ-023 In LOAD, the next edge SHALL set count <= LOAD, set presc_cnt <= 0 and move to RUN.
REQ-024 A CTRL write with EN=1 while EN is already 1 SHALL NOT restart the counter.
REQ-025 In RUN, a tick SHALL occur on each edge where presc_cnt >= PRESC; presc_cnt SHALL clear on a tick and increment otherwise.
REQ-026 A tick with count != 0 SHALL decrement count by 1.
REQ-027 A tick with count == 0 SHALL set FLAG=1; in periodic mode it SHALL also reload count <= LOAD, clear presc_cnt and stay in RUN.
REQ-028 A tick with count == 0 in one-shot mode SHALL also clear EN, hold count at 0 and go to IDLE.
REQ-029 The periodic expiry interval SHALL be (LOAD+1)*(PRESC+1) cycles.
REQ-030 The first expiry SHALL occur (LOAD+1)*(PRESC+1)+1 cycles after the EN commit edge.
REQ-031 A commit that writes EN=0 SHALL send the FSM to IDLE on that same commit edge; count SHALL freeze.
REQ-032 A later EN 0->1 write SHALL reload from LOAD.
REQ-033 A LOAD write during RUN SHALL NOT affect the current count; it SHALL take effect at the next reload.
REQ-034 A PRESC change during RUN SHALL apply immediately through the >= compare in REQ-025.
REQ-035 When an expiry sets FLAG on the same edge as a W1C of FLAG, the set SHALL win.
REQ-036 A one-shot expiry on the same edge as a CTRL write SHALL leave EN equal to the written value.
REQ-037 irq SHALL equal FLAG AND IE, registered-free.
REQ-038 count SHALL wrap never: it SHALL be bounded by LOAD, with no modular overflow.

Reset
REQ-039 While PRESETn=0, SHALL force state=IDLE and clear LOAD, CTRL, FLAG, count and presc_cnt to 0 immediately, including mid-run.
REQ-040 While PRESETn=0, SHALL hold PRDATA=0, PSLVERR=0, irq=0 and PREADY=1.
REQ-041 After PRESETn deasserts, the first APB transfer SHALL be accepted normally.

Verification
REQ-042 Reset then read addresses 0-3 -> all 0; PSLVERR=0 on every read.
REQ-043 LOAD=3, CTRL=0x07 (EN, periodic, IE, PRESC=0) -> irq=1 five cycles after the commit edge; COUNT reads 3,2,1,0 repeating; FLAG stays 1 until W1C 0x01.
REQ-044 LOAD=2, CTRL=0x15 (EN, one-shot, IE, PRESC=1) -> FLAG=1 seven cycles after commit; then CTRL reads 0x14, STATUS 0x01, COUNT 0.
REQ-045 W1C STATUS=0x01 committed on the expiry edge -> FLAG reads 1; write COUNT=0x55 -> PSLVERR=1 and COUNT unchanged.
REQ-046 Periodic run with LOAD=9: write EN=0 at COUNT=5 -> COUNT holds 5 and RUNNING=0; re-enable -> COUNT=9 two edges later.
REQ-047 Assert PRESETn mid-run -> irq, COUNT, CTRL and STATUS all 0 immediately; after release, a fresh LOAD=1 periodic sequence gives a 2-cycle period.

Source files
------------

// File: rtl/apb_timer_ctrl.sv
// APB-programmable down-counting timer with prescaler, one-shot/periodic modes
// and a level interrupt. Registers: LOAD, CTRL, STATUS (W1C flag), COUNT (RO).
module apb_timer_ctrl #(
    parameter int DW = 8,
    parameter int PW = 4
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [1:0]    PADDR,
    input  logic [DW-1:0] PWDATA,
    output logic [DW-1:0] PRDATA,
    output logic          PREADY,
    output logic          PSLVERR,
    output logic          irq
);

    localparam logic [1:0] ADDR_LOAD   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] load_q, load_d;
    logic [DW-1:0] count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [PW-1:0] presc_cnt_q, presc_cnt_d;
    logic          en_q, en_d;
    logic          mode_q, mode_d;
    logic          ie_q, ie_d;
    logic          flag_q, flag_d;

    logic          wr;
    logic          wr_load;
    logic          wr_ctrl;
    logic          wr_status;
    logic          stop;
    logic          tick;
    logic          expire;
    logic [DW-1:0] ctrl_rd;
    logic [DW-1:0] status_rd;
    logic [DW-1:0] rd_data;

    assign wr        = PSEL & PENABLE & PWRITE;
    assign wr_load   = wr && (PADDR == ADDR_LOAD);
    assign wr_ctrl   = wr && (PADDR == ADDR_CTRL);
    assign wr_status = wr && (PADDR == ADDR_STATUS);
    // Clearing EN preempts any counter activity on the same edge.
    assign stop      = wr_ctrl & ~PWDATA[0];
    assign tick      = (state_q == ST_RUN) && (presc_cnt_q >= presc_q);
    assign expire    = tick && (count_q == '0) && !stop;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        presc_cnt_d = presc_cnt_q;
        load_d      = wr_load ? PWDATA : load_q;
        en_d        = wr_ctrl ? PWDATA[0] : en_q;
        mode_d      = wr_ctrl ? PWDATA[1] : mode_q;
        ie_d        = wr_ctrl ? PWDATA[2] : ie_q;
        presc_d     = wr_ctrl ? PWDATA[4 +: PW] : presc_q;
        flag_d      = flag_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_ctrl && PWDATA[0] && !en_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d     = load_q;
                    presc_cnt_d = '0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    presc_cnt_d = '0;
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else if (mode_q) begin
                        count_d = load_q;
                    end else begin
                        state_d = ST_IDLE;
                        // A concurrent CTRL write keeps the written EN value.
                        if (!wr_ctrl) begin
                            en_d = 1'b0;
                        end
                    end
                end else begin
                    presc_cnt_d = presc_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Expiry is applied after W1C so that a simultaneous set wins.
        if (wr_status && PWDATA[0]) begin
            flag_d = 1'b0;
        end
        if (expire) begin
            flag_d = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            load_q      <= '0;
            count_q     <= '0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            en_q        <= 1'b0;
            mode_q      <= 1'b0;
            ie_q        <= 1'b0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_q      <= load_d;
            count_q     <= count_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            en_q        <= en_d;
            mode_q      <= mode_d;
            ie_q        <= ie_d;
            flag_q      <= flag_d;
        end
    end

    always_comb begin
        ctrl_rd         = '0;
        ctrl_rd[0]      = en_q;
        ctrl_rd[1]      = mode_q;
        ctrl_rd[2]      = ie_q;
        ctrl_rd[4 +: PW] = presc_q;

        status_rd    = '0;
        status_rd[0] = flag_q;
        status_rd[1] = (state_q != ST_IDLE);

        rd_data = '0;
        case (PADDR)
            ADDR_LOAD:   rd_data = load_q;
            ADDR_CTRL:   rd_data = ctrl_rd;
            ADDR_STATUS: rd_data = status_rd;
            ADDR_COUNT:  rd_data = count_q;
            default:     rd_data = '0;
        endcase
    end

    assign PRDATA  = (PSEL && PENABLE && !PWRITE) ? rd_data : '0;
    assign PREADY  = 1'b1;
    assign PSLVERR = wr && (PADDR == ADDR_COUNT) && PRESETn;
    assign irq     = flag_q & ie_q;

endmodule

// File: tb/tb_apb_timer_ctrl.sv
// Self-checking bench for apb_timer_ctrl: APB reads push expected data onto a
// scoreboard queue which is popped and compared in the access phase.
module tb_apb_timer_ctrl;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [1:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic       irq;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int c0;
    int c1;
    int cd;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];

    apb_timer_ctrl #(.DW(8), .PW(4)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Counter value e edges after the EN commit edge of a free-running periodic timer.
    function automatic int periodic_count(input int e, input int l, input int p);
        int ticks;
        ticks = (e - 1) / (p + 1);
        return l - (ticks % (l + 1));
    endfunction

    task automatic wait_edges(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Called just after a rising edge n; commits on edge n+2.
    task automatic apb_write(input logic [1:0] addr, input logic [7:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        check("pslverr_wr", PSLVERR, (addr == 2'd3) ? 1 : 0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // Called just after a rising edge n; samples the state left by edge n+1.
    task automatic apb_read(input logic [1:0] addr, input logic [7:0] exp, input string tag);
        exp_t e;
        e.tag = tag;
        e.val = exp;
        sb_q.push_back(e);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, PRDATA, e.val);
        end
        check("pslverr_rd", PSLVERR, 0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        PRESETn = 1'b0;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 2'd3; PWDATA = 8'hff;

        // Outputs held quiet while in reset, even with an error-type access presented.
        #3;
        check("rst_pslverr", PSLVERR, 0);
        check("rst_pready", PREADY, 1);
        check("rst_irq", irq, 0);
        PWRITE = 1'b0;
        for (int a = 0; a < 4; a++) begin
            PADDR = 2'(a);
            #1;
            check("rst_prdata", PRDATA, 0);
        end
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        PSEL = 1'b0; PENABLE = 1'b0;
        wait_edges(1);

        for (int a = 0; a < 4; a++) begin
            apb_read(2'(a), 8'h00, "post_rst_reg");
        end

        // Periodic, LOAD=3, PRESC=0.
        apb_write(2'd0, 8'd3);
        apb_write(2'd1, 8'h07);
        c0 = cyc;
        wait_edges(4);
        check("per_irq_early", irq, 0);
        wait_edges(1);
        check("per_irq_first", irq, 1);
        for (int i = 0; i < 6; i++) begin
            apb_read(2'd3, 8'(periodic_count(cyc + 1 - c0, 3, 0)), "per_count");
            if (i % 2 == 1) wait_edges(1);
        end
        apb_read(2'd2, 8'h03, "per_status_run");
        apb_write(2'd1, 8'h06);
        cd = cyc;
        apb_read(2'd3, 8'(periodic_count(cd - 1 - c0, 3, 0)), "per_count_frozen");
        apb_read(2'd2, 8'h01, "per_status_stopped");
        apb_read(2'd1, 8'h06, "per_ctrl_stopped");
        check("per_irq_held", irq, 1);
        apb_write(2'd2, 8'h01);
        apb_read(2'd2, 8'h00, "per_status_w1c");
        check("per_irq_cleared", irq, 0);

        // One-shot, LOAD=2, PRESC=1.
        apb_write(2'd0, 8'd2);
        apb_write(2'd1, 8'h15);
        wait_edges(6);
        check("os_irq_early", irq, 0);
        wait_edges(1);
        check("os_irq_expiry", irq, 1);
        apb_read(2'd1, 8'h14, "os_ctrl");
        apb_read(2'd2, 8'h01, "os_status");
        apb_read(2'd3, 8'h00, "os_count");
        wait_edges(5);
        apb_read(2'd3, 8'h00, "os_count_hold");
        apb_write(2'd2, 8'h01);

        // W1C colliding with a periodic expiry edge, then an illegal COUNT write.
        apb_write(2'd0, 8'd3);
        apb_write(2'd1, 8'h07);
        c0 = cyc;
        wait_edges(7);
        apb_write(2'd2, 8'h01);
        apb_read(2'd2, 8'h03, "flag_set_wins");
        apb_write(2'd3, 8'h55);
        apb_read(2'd3, 8'(periodic_count(cyc + 1 - c0, 3, 0)), "count_after_err");
        apb_read(2'd0, 8'd3, "load_after_err");
        apb_write(2'd1, 8'h00);
        apb_write(2'd2, 8'h01);
        apb_read(2'd2, 8'h00, "status_idle_clear");

        // Stop at COUNT=5, resume, and a redundant EN write must not restart.
        apb_write(2'd0, 8'd9);
        apb_write(2'd1, 8'h03);
        wait_edges(4);
        apb_write(2'd1, 8'h02);
        apb_read(2'd3, 8'd5, "stop_count");
        apb_read(2'd2, 8'h00, "stop_status");
        wait_edges(5);
        apb_read(2'd3, 8'd5, "stop_count_hold");
        apb_write(2'd1, 8'h03);
        c1 = cyc;
        apb_read(2'd3, 8'd9, "resume_reload");
        apb_read(2'd3, 8'(periodic_count(cyc + 1 - c1, 9, 0)), "resume_count");
        apb_write(2'd1, 8'h03);
        apb_read(2'd3, 8'(periodic_count(cyc + 1 - c1, 9, 0)), "no_restart_count");
        apb_write(2'd1, 8'h00);

        // Reset asserted mid-run with irq high.
        apb_write(2'd0, 8'd2);
        apb_write(2'd1, 8'h07);
        wait_edges(5);
        check("mid_irq_before_rst", irq, 1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("mid_rst_irq", irq, 0);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0;
        for (int a = 1; a < 4; a++) begin
            PADDR = 2'(a);
            #1;
            check("mid_rst_prdata", PRDATA, 0);
        end
        check("mid_rst_pready", PREADY, 1);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        wait_edges(1);
        apb_write(2'd0, 8'd1);
        apb_read(2'd0, 8'd1, "post_rst_load");
        apb_read(2'd1, 8'h00, "post_rst_ctrl");
        apb_write(2'd1, 8'h07);
        c0 = cyc;
        wait_edges(2);
        check("fresh_irq_early", irq, 0);
        wait_edges(1);
        check("fresh_irq_first", irq, 1);
        for (int i = 0; i < 4; i++) begin
            apb_read(2'd3, 8'(periodic_count(cyc + 1 - c0, 1, 0)), "fresh_count");
            if (i % 2 == 0) wait_edges(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
